// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART blocks.
//   tx_state_t       : transmitter FSM states
//   PARITY_*         : parity mode selectors
//   DEFAULT_BAUD_INC : accumulator increment for ~115200 baud at 50 MHz
// ---------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;

   localparam int unsigned PARITY_NONE = 0;
   localparam int unsigned PARITY_EVEN = 1;
   localparam int unsigned PARITY_ODD  = 2;

   localparam int unsigned DEFAULT_BAUD_INC = 151;

endpackage

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
// 16-bit phase-accumulator bit-rate generator.
//   clk      in  : system clock
//   reset_n  in  : synchronous active-low reset
//   clear    in  : hold accumulator and tick at zero while high
//   bit_tick out : registered carry out of bit 15, one cycle wide
// Bit rate = f_clk * BAUD_INC / 65536.
// ---------------------------------------------------------------------------
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int unsigned BAUD_INC = DEFAULT_BAUD_INC
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   output logic bit_tick
);

   logic [15:0] acc_q, acc_d;
   logic        tick_q, tick_d;
   logic [16:0] sum;

   always_comb begin
      sum = {1'b0, acc_q} + 17'(BAUD_INC);
      if (clear) begin
         acc_d  = '0;
         tick_d = 1'b0;
      end else begin
         acc_d  = sum[15:0];
         tick_d = sum[16];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         acc_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         tick_q <= tick_d;
      end
   end

   assign bit_tick = tick_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Buffered UART transmitter: byte FIFO in front of a start/8 data (LSB first)/
// optional parity/1-2 stop bit serialiser.
//   clock50    in  : 50 MHz system clock
//   reset_n    in  : synchronous active-low reset (aborts any frame)
//   in_data    in  : byte to transmit
//   in_valid   in  : producer offers in_data
//   in_ready   out : FIFO not full
//   tx         out : serial line, idle high (registered)
//   busy       out : frame in progress or FIFO non-empty
//   fifo_count out : FIFO occupancy (registered)
// Handshake: a byte is transferred at a rising edge where in_valid && in_ready;
// in_ready depends only on the registered occupancy, never on in_valid.
// ---------------------------------------------------------------------------
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned BAUD_INC   = DEFAULT_BAUD_INC,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned PARITY     = PARITY_NONE,
   parameter int unsigned STOP_BITS  = 1
) (
   input  logic                        clock50,
   input  logic                        reset_n,
   input  logic [7:0]                  in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic                        tx,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int unsigned      PTR_W      = $clog2(FIFO_DEPTH);
   localparam int unsigned      CNT_W      = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
   localparam logic             ODD_FLIP   = (PARITY == PARITY_ODD);

   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [7:0]       mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   tx_state_t        state_q, state_d;
   logic [7:0]       shreg_q, shreg_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic             par_q, par_d;
   logic             stop_cnt_q, stop_cnt_d;
   logic             tx_q, tx_d;

   logic             push, pop, stop_last;
   logic             bit_tick, baud_clear;

   assign in_ready = (count_q != FULL_COUNT);

   // FIFO bookkeeping; pop is the IDLE state taking the head entry
   always_comb begin
      push     = in_valid && in_ready;
      pop      = (state_q == ST_IDLE) && (count_q != '0);
      mem_d    = mem_q;
      if (push) mem_d[wr_ptr_q] = in_data;
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Serialiser
   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      bit_idx_d  = bit_idx_q;
      par_d      = par_q;
      stop_cnt_d = stop_cnt_q;
      tx_d       = tx_q;
      stop_last  = (STOP_BITS == 1) || stop_cnt_q;
      case (state_q)
         ST_IDLE: begin
            tx_d = 1'b1;
            if (pop) begin
               shreg_d   = mem_q[rd_ptr_q];
               tx_d      = 1'b0;
               bit_idx_d = 3'd0;
               par_d     = 1'b0;
               state_d   = ST_START;
            end
         end
         ST_START: begin
            if (bit_tick) begin
               tx_d    = shreg_q[0];
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_tick) begin
               // shreg_q[0] is the bit whose period just ended
               par_d   = par_q ^ shreg_q[0];
               shreg_d = {1'b0, shreg_q[7:1]};
               if (bit_idx_q == 3'd7) begin
                  stop_cnt_d = 1'b0;
                  if (PARITY != PARITY_NONE) begin
                     tx_d    = par_q ^ shreg_q[0] ^ ODD_FLIP;
                     state_d = ST_PARITY;
                  end else begin
                     tx_d    = 1'b1;
                     state_d = ST_STOP;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  tx_d      = shreg_q[1];
               end
            end
         end
         ST_PARITY: begin
            if (bit_tick) begin
               tx_d       = 1'b1;
               stop_cnt_d = 1'b0;
               state_d    = ST_STOP;
            end
         end
         ST_STOP: begin
            if (bit_tick) begin
               if (stop_last) state_d    = ST_IDLE;
               else           stop_cnt_d = 1'b1;
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
      // Clearing on the next state lets the accumulator take its first step on
      // the edge that leaves IDLE, so the start bit is a full bit period.
      baud_clear = (state_d == ST_IDLE);
   end

   uart_baud_gen #(
      .BAUD_INC (BAUD_INC)
   ) u_baud (
      .clk      (clock50),
      .reset_n  (reset_n),
      .clear    (baud_clear),
      .bit_tick (bit_tick)
   );

   always_ff @(posedge clock50) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         state_q    <= ST_IDLE;
         shreg_q    <= '0;
         bit_idx_q  <= '0;
         par_q      <= 1'b0;
         stop_cnt_q <= 1'b0;
         tx_q       <= 1'b1;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         bit_idx_q  <= bit_idx_d;
         par_q      <= par_d;
         stop_cnt_q <= stop_cnt_d;
         tx_q       <= tx_d;
      end
   end

   // Storage needs no reset: entries are only read after being written
   always_ff @(posedge clock50) begin
      mem_q <= mem_d;
   end

   assign tx         = tx_q;
   assign fifo_count = count_q;
   assign busy       = (state_q != ST_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
// Three instances share clock and reset:
//   dut0 : defaults (151, depth 4, no parity, 1 stop)
//   dut1 : even parity, 2 stop bits, faster bit rate
//   dut2 : odd parity, 1 stop bit, faster bit rate
// Frames are checked cycle by cycle against bit boundaries computed as
// ceil(n*65536/BAUD_INC) from the falling edge of the start bit.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic        reset_n;
   logic [7:0]  in_data    [3];
   logic        in_valid   [3];
   logic        in_ready   [3];
   logic        tx         [3];
   logic        busy       [3];
   logic [2:0]  fifo_count [3];

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;
   logic [7:0] exp_q[$];

   uart_tx_fifo #(.BAUD_INC(151), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1)) dut0 (
      .clock50(clk), .reset_n(reset_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
      .in_ready(in_ready[0]), .tx(tx[0]), .busy(busy[0]), .fifo_count(fifo_count[0]));

   uart_tx_fifo #(.BAUD_INC(2000), .FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(2)) dut1 (
      .clock50(clk), .reset_n(reset_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
      .in_ready(in_ready[1]), .tx(tx[1]), .busy(busy[1]), .fifo_count(fifo_count[1]));

   uart_tx_fifo #(.BAUD_INC(2000), .FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(1)) dut2 (
      .clock50(clk), .reset_n(reset_n), .in_data(in_data[2]), .in_valid(in_valid[2]),
      .in_ready(in_ready[2]), .tx(tx[2]), .busy(busy[2]), .fifo_count(fifo_count[2]));

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   // ---------------- reference model ----------------
   function automatic int unsigned inc_of(input int s);
      return (s == 0) ? 151 : 2000;
   endfunction

   function automatic int par_of(input int s);
      return s;  // dut0 none, dut1 even, dut2 odd
   endfunction

   function automatic int stop_of(input int s);
      return (s == 1) ? 2 : 1;
   endfunction

   function automatic int unsigned nbits_of(input int s);
      return 1 + 8 + ((par_of(s) != 0) ? 1 : 0) + stop_of(s);
   endfunction

   // cycle (from start-bit edge) at which bit period n begins
   function automatic int unsigned bnd(input int unsigned inc, input int unsigned n);
      return (n * 65536 + inc - 1) / inc;
   endfunction

   function automatic logic frame_bit(input int s, input logic [7:0] b, input int k);
      int p;
      p = par_of(s);
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      if (p != 0 && k == 9) return (^b) ^ (p == 2);
      return 1'b1;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int s, input logic [7:0] d, input bit keep, output int unsigned acc_cyc);
      logic rdy;
      bit   ok;
      ok = 1'b0;
      in_valid[s] = 1'b1;
      in_data[s]  = d;
      acc_cyc     = cyc;
      for (int i = 0; i < 20000 && !ok; i++) begin
         rdy = in_ready[s];
         step();
         if (rdy) ok = 1'b1;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL push_accept dut%0d: byte %02h not accepted within 20000 cycles", s, d);
      end else begin
         acc_cyc = cyc;
         exp_q.push_back(d);
      end
      if (!keep) in_valid[s] = 1'b0;
   endtask

   // Waits for a start bit, then checks every cycle of every bit of the frame.
   // Returns with cyc == te, the edge at which the frame has ended.
   task automatic check_frame(input int s, output int unsigned t0, output int unsigned te);
      int unsigned waited, nb, inc, lo, hi, bad;
      logic [7:0]  b;
      logic        eb, seen;
      waited = 0;
      while (tx[s] !== 1'b0 && waited < 30000) begin
         step();
         waited++;
      end
      checks++;
      if (tx[s] !== 1'b0) begin
         errors++;
         $display("FAIL frame_start dut%0d: tx=%b after %0d cycles, required 0", s, tx[s], waited);
         t0 = cyc;
         te = cyc;
         return;
      end
      t0 = cyc;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL frame_unexpected dut%0d: frame started at cycle %0d, required no frame", s, t0);
         b = 8'h00;
      end else begin
         b = exp_q.pop_front();
      end
      inc = inc_of(s);
      nb  = nbits_of(s);
      for (int k = 0; k < int'(nb); k++) begin
         eb   = frame_bit(s, b, k);
         lo   = bnd(inc, k);
         hi   = bnd(inc, k + 1);
         bad  = 0;
         seen = eb;
         for (int unsigned c = lo; c < hi; c++) begin
            if (tx[s] !== eb) begin
               bad++;
               seen = tx[s];
            end
            if (k == int'(nb) - 1 && c == hi - 1) begin
               checks++;
               if (busy[s] !== 1'b1) begin
                  errors++;
                  $display("FAIL frame_busy dut%0d: busy=%b in last stop cycle, required 1", s, busy[s]);
               end
            end
            step();
         end
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL frame_bit dut%0d byte %02h bit %0d: tx=%b on %0d of %0d cycles, required %b",
                     s, b, k, seen, bad, hi - lo, eb);
         end
      end
      te = t0 + bnd(inc, nb);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) step();
      for (int s = 0; s < 3; s++) begin
         checks++;
         if (tx[s] !== 1'b1) begin errors++; $display("FAIL reset_tx dut%0d: tx=%b, required 1", s, tx[s]); end
         checks++;
         if (busy[s] !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d: busy=%b, required 0", s, busy[s]); end
         checks++;
         if (fifo_count[s] !== 3'd0) begin errors++; $display("FAIL reset_count dut%0d: fifo_count=%0d, required 0", s, fifo_count[s]); end
         checks++;
         if (in_ready[s] !== 1'b1) begin errors++; $display("FAIL reset_ready dut%0d: in_ready=%b, required 1", s, in_ready[s]); end
      end
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_single();
      int unsigned acc, t0, te;
      exp_q.delete();
      push(0, 8'h55, 1'b0, acc);
      checks++;
      if (tx[0] !== 1'b1 || fifo_count[0] !== 3'd1 || busy[0] !== 1'b1) begin
         errors++;
         $display("FAIL single_accept: tx=%b count=%0d busy=%b, required 1/1/1", tx[0], fifo_count[0], busy[0]);
      end
      step();
      checks++;
      if (tx[0] !== 1'b0 || fifo_count[0] !== 3'd0) begin
         errors++;
         $display("FAIL single_latency: tx=%b count=%0d one edge after accept, required 0/0", tx[0], fifo_count[0]);
      end
      check_frame(0, t0, te);
      checks++;
      if (t0 != acc + 1) begin
         errors++;
         $display("FAIL single_start_cycle: start at %0d, required %0d", t0, acc + 1);
      end
      checks++;
      if (busy[0] !== 1'b0 || tx[0] !== 1'b1 || cyc != acc + 4342) begin
         errors++;
         $display("FAIL single_busy_end: busy=%b tx=%b at cycle %0d, required 0/1 at %0d", busy[0], tx[0], cyc - acc, 4342);
      end
   endtask

   task automatic test_back_to_back();
      int unsigned acc[3], t0[3], te[3];
      logic [7:0]  bytes[3];
      bytes[0] = 8'h00;
      bytes[1] = 8'hFF;
      bytes[2] = 8'hA5;
      exp_q.delete();
      fork
         begin
            for (int i = 0; i < 3; i++) push(0, bytes[i], (i < 2), acc[i]);
         end
         begin
            for (int i = 0; i < 3; i++) check_frame(0, t0[i], te[i]);
         end
      join
      for (int i = 1; i < 3; i++) begin
         checks++;
         if (acc[i] != acc[i-1] + 1) begin
            errors++;
            $display("FAIL b2b_stall: byte %0d accepted at %0d, required %0d", i, acc[i], acc[i-1] + 1);
         end
         checks++;
         if (t0[i] != te[i-1] + 1) begin
            errors++;
            $display("FAIL b2b_gap: frame %0d starts %0d cycles after previous end, required 1", i, t0[i] - te[i-1]);
         end
      end
      checks++;
      if (t0[0] != acc[0] + 1) begin
         errors++;
         $display("FAIL b2b_first_start: start at %0d, required %0d", t0[0], acc[0] + 1);
      end
      checks++;
      if (busy[0] !== 1'b0 || fifo_count[0] !== 3'd0) begin
         errors++;
         $display("FAIL b2b_drained: busy=%b count=%0d, required 0/0", busy[0], fifo_count[0]);
      end
   endtask

   task automatic test_fill();
      int unsigned acc[6], t0[6], te[6];
      exp_q.delete();
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               push(0, 8'($urandom_range(0, 255)), (i < 5), acc[i]);
               if (i == 4) begin
                  checks++;
                  if (fifo_count[0] !== 3'd4 || in_ready[0] !== 1'b0) begin
                     errors++;
                     $display("FAIL fill_full: count=%0d in_ready=%b, required 4/0", fifo_count[0], in_ready[0]);
                  end
                  checks++;
                  if (acc[4] != acc[0] + 4) begin
                     errors++;
                     $display("FAIL fill_stall: 5th byte accepted at +%0d, required +4", acc[4] - acc[0]);
                  end
               end
            end
         end
         begin
            for (int i = 0; i < 6; i++) check_frame(0, t0[i], te[i]);
         end
      join
      checks++;
      if (acc[5] != te[0] + 2) begin
         errors++;
         $display("FAIL fill_sixth_accept: accepted at %0d, required %0d", acc[5], te[0] + 2);
      end
      for (int i = 1; i < 6; i++) begin
         checks++;
         if (t0[i] != te[i-1] + 1) begin
            errors++;
            $display("FAIL fill_gap: frame %0d starts %0d cycles after previous end, required 1", i, t0[i] - te[i-1]);
         end
      end
      checks++;
      if (busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL fill_drained: busy=%b, required 0", busy[0]);
      end
   endtask

   task automatic test_parity();
      int unsigned acc, t0, te;
      for (int s = 1; s < 3; s++) begin
         exp_q.delete();
         push(s, 8'h07, 1'b0, acc);
         check_frame(s, t0, te);
         checks++;
         if (busy[s] !== 1'b0 || tx[s] !== 1'b1) begin
            errors++;
            $display("FAIL parity_end dut%0d: busy=%b tx=%b after %0d bit periods, required 0/1", s, busy[s], tx[s], nbits_of(s));
         end
      end
   endtask

   task automatic test_random();
      int unsigned acc, t0, te, gap;
      for (int s = 1; s < 3; s++) begin
         exp_q.delete();
         for (int n = 0; n < 5; n++) begin
            gap = $urandom_range(0, 40);
            repeat (gap) step();
            push(s, 8'($urandom_range(0, 255)), 1'b0, acc);
            check_frame(s, t0, te);
            checks++;
            if (t0 != acc + 1 || busy[s] !== 1'b0) begin
               errors++;
               $display("FAIL random dut%0d: start at +%0d busy=%b, required +1/0", s, t0 - acc, busy[s]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int unsigned a, t0, te, target, waited, bad;
      exp_q.delete();
      fork
         begin
            push(0, 8'($urandom_range(0, 255)) & 8'hF7, 1'b1, a);
            push(0, 8'($urandom_range(0, 255)), 1'b1, a);
            push(0, 8'($urandom_range(0, 255)), 1'b0, a);
         end
         begin
            waited = 0;
            while (tx[0] !== 1'b0 && waited < 30000) begin
               step();
               waited++;
            end
            t0     = cyc;
            target = t0 + bnd(151, 4) + 20;
            while (cyc < target) step();
            checks++;
            if (tx[0] !== 1'b0 || fifo_count[0] !== 3'd2) begin
               errors++;
               $display("FAIL rmid_before: tx=%b count=%0d in data bit 3, required 0/2", tx[0], fifo_count[0]);
            end
            reset_n = 1'b0;
            step();
            checks++;
            if (tx[0] !== 1'b1 || fifo_count[0] !== 3'd0 || busy[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
               errors++;
               $display("FAIL rmid_edge: tx=%b count=%0d busy=%b ready=%b, required 1/0/0/1",
                        tx[0], fifo_count[0], busy[0], in_ready[0]);
            end
            reset_n = 1'b1;
         end
      join
      exp_q.delete();
      bad = 0;
      repeat (1000) begin
         if (tx[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
         step();
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL rmid_quiet: activity on %0d of 1000 cycles after reset, required 0", bad);
      end
      push(0, 8'($urandom_range(0, 255)), 1'b0, a);
      check_frame(0, t0, te);
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      reset_n = 1'b0;
      for (int s = 0; s < 3; s++) begin
         in_valid[s] = 1'b0;
         in_data[s]  = 8'h00;
      end
      step();
      test_reset();
      test_single();
      test_back_to_back();
      test_fill();
      test_parity();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
